serial_chain_scheduler: RTL

Shares one serial shift engine between the board's three shift-register chains: LED bar, 7-segment and LCD. Each requester presents a parallel word. The block grants requesters round-robin, shifts the granted word MSB-first onto that chain's data line and pulses that chain's latch. It sits between the display drivers and the board pins, clocked by the peripheral clock that also drives the external shift registers.

---
 rtl/serial_chain_pkg.sv | 19 +
 rtl/serial_chain_scheduler_rr_pick.sv | 29 ++
 rtl/serial_chain_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_chain_pkg.sv
// Shared types and constants for the serial chain scheduler.
package serial_chain_pkg;

    // Engine states: waiting for a grant, shifting bits, pulsing the latch.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Requester indices on the board.
    localparam int REQ_LED = 0;
    localparam int REQ_SEG = 1;
    localparam int REQ_LCD = 2;

    // Default word width shifted per transaction.
    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/serial_chain_scheduler_rr_pick.sv
// Combinational round-robin selector: first active request after last_grant.
module rr_pick
    import serial_chain_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    // Walk the requesters starting one past the previous winner, take the first set one.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_grant) + off) % N_REQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_chain_scheduler.sv
// Shares one MSB-first shift engine between several shift-register chains.
module serial_chain_scheduler
    import serial_chain_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int N_REQ  = 3
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET,
    input  logic [N_REQ-1:0]        i_Req,
    input  logic [N_REQ*DATA_W-1:0] i_Data,
    output logic [N_REQ-1:0]        o_Ack,
    output logic [N_REQ-1:0]        o_Done,
    output logic [N_REQ-1:0]        o_SerData,
    output logic [N_REQ-1:0]        o_Latch,
    output logic                    o_Busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(DATA_W);

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_grant;
    logic [N_REQ-1:0]   ack_q;
    logic [IDX_W-1:0]   pick_grant;
    logic               pick_valid_raw;
    logic               pick_valid;
    logic               cnt_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (i_Req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid_raw)
    );

    // A grant is only taken while the engine is idle.
    assign pick_valid = pick_valid_raw && (state == ST_IDLE);
    assign cnt_last   = (cnt == CNT_W'(DATA_W - 1));

    // State register.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: one grant per idle cycle, DATA_W shift cycles, one latch cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt_last)   state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Capture the granted word at the grant edge, then shift left with zero fill.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            shreg      <= '0;
            cnt        <= '0;
            grant_q    <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            ack_q      <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        shreg             <= i_Data[int'(pick_grant)*DATA_W +: DATA_W];
                        grant_q           <= pick_grant;
                        last_grant        <= pick_grant;
                        cnt               <= '0;
                        ack_q[pick_grant] <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shreg <= {shreg[DATA_W-2:0], 1'b0};
                    if (!cnt_last) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state only; non-granted chains stay at 0.
    always_comb begin
        o_SerData = '0;
        o_Latch   = '0;
        if (state == ST_SHIFT) o_SerData[grant_q] = shreg[DATA_W-1];
        if (state == ST_LATCH) o_Latch[grant_q]   = 1'b1;
    end

    assign o_Done = o_Latch;
    assign o_Ack  = ack_q;
    assign o_Busy = (state != ST_IDLE);

endmodule
